// File: rtl/tc_mul_pkg.sv
// Shared definitions for the TrackletCalculator multiplier family.
// Contents:
//   NUM_STAGE_MIN/MAX : legal pipeline depth range
//   full_w()          : width of the exact signed x unsigned product
//   sat_hi()/sat_lo() : signed saturation bounds for a P_W-bit result
//   cfg_ok()          : parameter legality check used at elaboration
package tc_mul_pkg;

    localparam int NUM_STAGE_MIN = 1;
    localparam int NUM_STAGE_MAX = 6;
    // Bounds are computed at this width and then sliced to the result width.
    localparam int BOUND_W       = 64;

    function automatic int full_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic logic signed [BOUND_W-1:0] sat_hi(input int p_w);
        return (64'sd1 <<< (p_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [BOUND_W-1:0] sat_lo(input int p_w);
        return -(64'sd1 <<< (p_w - 1));
    endfunction

    function automatic bit cfg_ok(input int num_stage, input int shift,
                                  input int a_w, input int b_w);
        return (num_stage >= NUM_STAGE_MIN) && (num_stage <= NUM_STAGE_MAX) &&
               (shift >= 0) && (shift < full_w(a_w, b_w));
    endfunction

endpackage

// File: rtl/tc_mul_pipe_if.sv
// Handshake bundle of tc_mul_pipe.
// Input side : in_valid/in_ready, din0 (signed), din1 (unsigned), in_tag
// Output side: out_valid/out_ready, dout, out_tag, ovf
// Status     : ovf_sticky, clr_sticky
// master = producer/consumer around the multiplier, slave = the multiplier.
interface tc_mul_pipe_if
    import tc_mul_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 11,
    parameter int P_W   = 29,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   din0;
    logic [B_W-1:0]   din1;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   dout;
    logic [TAG_W-1:0] out_tag;
    logic             ovf;
    logic             ovf_sticky;
    logic             clr_sticky;

    modport master (
        output in_valid, din0, din1, in_tag, out_ready, clr_sticky,
        input  in_ready, out_valid, dout, out_tag, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, din0, din1, in_tag, out_ready, clr_sticky,
        output in_ready, out_valid, dout, out_tag, ovf, ovf_sticky
    );
endinterface

// File: rtl/tc_mul_narrow.sv
// Combinational round / arithmetic shift / saturate-or-wrap of a signed value.
// Ports:
//   prod : signed IN_W-bit input value
//   dout : P_W-bit result (clamped when SAT=1, low bits when SAT=0)
//   ovf  : the shifted value does not fit the signed P_W range
module tc_mul_narrow
    import tc_mul_pkg::*;
#(
    parameter int IN_W  = 29,
    parameter int P_W   = 29,
    parameter int SHIFT = 0,
    parameter int ROUND = 0,
    parameter int SAT   = 0
) (
    input  logic signed [IN_W-1:0] prod,
    output logic        [P_W-1:0]  dout,
    output logic                   ovf
);
    // One extra bit so the rounding addend can never overflow.
    localparam int RW      = IN_W + 1;
    localparam bit DO_RND  = (ROUND != 0) && (SHIFT > 0);
    localparam int EFF_W   = IN_W - SHIFT + (DO_RND ? 1 : 0);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND =
        DO_RND ? ({{(RW-1){1'b0}}, 1'b1} << RND_POS) : '0;

    logic signed [RW-1:0] rounded_s;
    logic signed [RW-1:0] shifted_s;

    assign rounded_s = RW'(prod) + RND;
    assign shifted_s = rounded_s >>> SHIFT;

    if (P_W >= EFF_W) begin : g_fits
        // Every shifted value is representable, so a resize is exact.
        assign dout = P_W'(shifted_s);
        assign ovf  = 1'b0;
    end else begin : g_narrow
        localparam logic signed [BOUND_W-1:0] HI_W = sat_hi(P_W);
        localparam logic signed [BOUND_W-1:0] LO_W = sat_lo(P_W);
        localparam logic [P_W-1:0] HI = HI_W[P_W-1:0];
        localparam logic [P_W-1:0] LO = LO_W[P_W-1:0];

        // The value fits iff all bits from the result sign bit upward agree.
        logic [RW-P_W:0] top_s;
        assign top_s = shifted_s[RW-1:P_W-1];
        assign ovf   = ~((&top_s) | ~(|top_s));

        // Select clamped bound or wrapped low bits.
        always_comb begin
            dout = shifted_s[P_W-1:0];
            if ((SAT != 0) && ovf) begin
                if (top_s[RW-P_W]) begin
                    dout = LO;
                end else begin
                    dout = HI;
                end
            end else begin
                dout = shifted_s[P_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tc_mul_pipe.sv
// Pipelined signed(din0) x unsigned(din1) multiplier with valid/ready flow
// control, optional rounding shift, saturation and overflow reporting.
// Ports:
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   bus (slave)    : operand/result handshake, tag sideband, ovf/ovf_sticky
// Structure: NUM_STAGE-1 operand registers, then the multiply and narrow
// feed the output register. Whole pipe advances when the output is free.
module tc_mul_pipe
    import tc_mul_pkg::*;
#(
    parameter int A_W       = 18,
    parameter int B_W       = 11,
    parameter int P_W       = 29,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SAT       = 0,
    parameter int NUM_STAGE = 3,
    parameter int TAG_W     = 8
) (
    input logic          ap_clk,
    input logic          ap_rst,
    tc_mul_pipe_if.slave bus
);
    localparam int FW = full_w(A_W, B_W);

    if (!cfg_ok(NUM_STAGE, SHIFT, A_W, B_W)) begin : g_bad_cfg
        $error("tc_mul_pipe: NUM_STAGE must be 1..6 and SHIFT < A_W+B_W");
    end

    logic                    adv_s;
    logic signed [A_W-1:0]   src_a_s;
    logic        [B_W-1:0]   src_b_s;
    logic        [TAG_W-1:0] src_tag_s;
    logic                    src_vld_s;
    logic signed [FW-1:0]    prod_s;
    logic        [P_W-1:0]   nar_dout_s;
    logic                    nar_ovf_s;
    logic                    out_vld_r;
    logic        [P_W-1:0]   dout_r;
    logic        [TAG_W-1:0] tag_r;
    logic                    ovf_r;
    logic                    sticky_r;

    // An empty or draining output slot lets every stage move one step.
    assign adv_s = bus.out_ready | ~out_vld_r;

    if (NUM_STAGE == 1) begin : g_direct
        assign src_a_s   = bus.din0;
        assign src_b_s   = bus.din1;
        assign src_tag_s = bus.in_tag;
        assign src_vld_s = bus.in_valid;
    end else begin : g_opnd
        localparam int D = NUM_STAGE - 1;
        logic [A_W-1:0]   a_r   [D];
        logic [B_W-1:0]   b_r   [D];
        logic [TAG_W-1:0] tg_r  [D];
        logic             vld_r [D];

        // Operand delay line; stage 0 captures the accepted input beat.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                for (int i = 0; i < D; i++) begin
                    vld_r[i] <= 1'b0;
                    a_r[i]   <= '0;
                    b_r[i]   <= '0;
                    tg_r[i]  <= '0;
                end
            end else if (adv_s) begin
                vld_r[0] <= bus.in_valid;
                a_r[0]   <= bus.din0;
                b_r[0]   <= bus.din1;
                tg_r[0]  <= bus.in_tag;
                for (int i = 1; i < D; i++) begin
                    vld_r[i] <= vld_r[i-1];
                    a_r[i]   <= a_r[i-1];
                    b_r[i]   <= b_r[i-1];
                    tg_r[i]  <= tg_r[i-1];
                end
            end
        end

        assign src_a_s   = a_r[D-1];
        assign src_b_s   = b_r[D-1];
        assign src_tag_s = tg_r[D-1];
        assign src_vld_s = vld_r[D-1];
    end

    // din1 gets a zero sign bit so it multiplies as a non-negative value.
    assign prod_s = FW'(src_a_s) * FW'($signed({1'b0, src_b_s}));

    tc_mul_narrow #(
        .IN_W  (FW),
        .P_W   (P_W),
        .SHIFT (SHIFT),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_narrow (
        .prod (prod_s),
        .dout (nar_dout_s),
        .ovf  (nar_ovf_s)
    );

    // Output register: holds its beat while downstream stalls.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_vld_r <= 1'b0;
            dout_r    <= '0;
            tag_r     <= '0;
            ovf_r     <= 1'b0;
        end else if (adv_s) begin
            out_vld_r <= src_vld_s;
            dout_r    <= nar_dout_s;
            tag_r     <= src_tag_s;
            ovf_r     <= nar_ovf_s;
        end
    end

    // Sticky overflow flag; a clear request wins over a same-cycle set.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sticky_r <= 1'b0;
        end else if (bus.clr_sticky) begin
            sticky_r <= 1'b0;
        end else if (out_vld_r && bus.out_ready && ovf_r) begin
            sticky_r <= 1'b1;
        end
    end

    assign bus.in_ready   = adv_s;
    assign bus.out_valid  = out_vld_r;
    assign bus.dout       = dout_r;
    assign bus.out_tag    = tag_r;
    assign bus.ovf        = ovf_r;
    assign bus.ovf_sticky = sticky_r;

endmodule

// File: tb/tb_tc_mul_pipe.sv
module tb_tc_mul_pipe;

    logic        clk;
    logic        ap_rst;
    logic        in_valid;
    logic        out_ready;
    logic        clr_sticky;
    logic [17:0] din0;
    logic [10:0] din1;
    logic [7:0]  in_tag;

    int checks;
    int errors;

    // i0 defaults, i1 shift4+round, i2 shift4 no round, i3 sat16, i4 wrap16,
    // i5 single stage, i6 six stages.
    tc_mul_pipe_if             i0 ();
    tc_mul_pipe_if #(.P_W(16)) i1 ();
    tc_mul_pipe_if #(.P_W(16)) i2 ();
    tc_mul_pipe_if #(.P_W(16)) i3 ();
    tc_mul_pipe_if #(.P_W(16)) i4 ();
    tc_mul_pipe_if             i5 ();
    tc_mul_pipe_if             i6 ();

    assign {i0.in_valid, i0.din0, i0.din1, i0.in_tag, i0.out_ready, i0.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};
    assign {i1.in_valid, i1.din0, i1.din1, i1.in_tag, i1.out_ready, i1.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};
    assign {i2.in_valid, i2.din0, i2.din1, i2.in_tag, i2.out_ready, i2.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};
    assign {i3.in_valid, i3.din0, i3.din1, i3.in_tag, i3.out_ready, i3.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};
    assign {i4.in_valid, i4.din0, i4.din1, i4.in_tag, i4.out_ready, i4.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};
    assign {i5.in_valid, i5.din0, i5.din1, i5.in_tag, i5.out_ready, i5.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};
    assign {i6.in_valid, i6.din0, i6.din1, i6.in_tag, i6.out_ready, i6.clr_sticky} = {in_valid, din0, din1, in_tag, out_ready, clr_sticky};

    tc_mul_pipe                                       u0 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i0.slave));
    tc_mul_pipe #(.P_W(16), .SHIFT(4), .ROUND(1))     u1 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i1.slave));
    tc_mul_pipe #(.P_W(16), .SHIFT(4), .ROUND(0))     u2 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i2.slave));
    tc_mul_pipe #(.P_W(16), .SAT(1))                  u3 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i3.slave));
    tc_mul_pipe #(.P_W(16), .SAT(0))                  u4 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i4.slave));
    tc_mul_pipe #(.NUM_STAGE(1))                      u5 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i5.slave));
    tc_mul_pipe #(.NUM_STAGE(6))                      u6 (.ap_clk(clk), .ap_rst(ap_rst), .bus(i6.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] a;
        logic [10:0] b;
        logic [28:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e3;
        logic [15:0] e4;
        logic [3:0]  ov;   // ovf of i1..i4 in bits 0..3
    } vec_t;
    vec_t vt [5];

    typedef struct packed {
        logic [7:0]  tag;
        logic [28:0] prod;
    } sb_t;
    sb_t sbq [3][$];
    int  n_out [3];
    bit  sb_en;

    logic [28:0] hold_d;
    logic [7:0]  hold_t;
    logic        stale;
    int          sent;
    logic [7:0]  tagc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] ref_prod(input logic [17:0] a, input logic [10:0] b);
        longint p;
        p = longint'($signed(a)) * longint'(b);
        return p[28:0];
    endfunction

    task automatic mon(input int k, input logic ir, input logic ov, input logic [28:0] d,
                       input logic [7:0] ot, input logic of);
        sb_t e;
        if (ov && out_ready) begin
            if (sbq[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb%0d_extra: got beat tag %0h, expected no beat", k, ot);
            end else begin
                e = sbq[k].pop_front();
                chk($sformatf("sb%0d_tag", k), 64'(ot), 64'(e.tag));
                chk($sformatf("sb%0d_dout", k), 64'(d), 64'(e.prod));
                chk($sformatf("sb%0d_ovf", k), 64'(of), 64'd0);
                n_out[k]++;
            end
        end
        if (in_valid && ir) begin
            e.tag  = in_tag;
            e.prod = ref_prod(din0, din1);
            sbq[k].push_back(e);
        end
    endtask

    // Scoreboards for the three default-format instances; reset drops in-flight beats.
    always @(negedge clk) begin
        if (ap_rst) begin
            for (int k = 0; k < 3; k++) sbq[k].delete();
        end else if (sb_en) begin
            mon(0, i0.in_ready, i0.out_valid, i0.dout, i0.out_tag, i0.ovf);
            mon(1, i5.in_ready, i5.out_valid, i5.dout, i5.out_tag, i5.ovf);
            mon(2, i6.in_ready, i6.out_valid, i6.dout, i6.out_tag, i6.ovf);
        end
    end

    task automatic send_one(input logic [17:0] a, input logic [10:0] b, input logic [7:0] t);
        @(posedge clk); #1;
        in_valid = 1'b1; din0 = a; din1 = b; in_tag = t;
        @(negedge clk);
        chk("send_in_ready", 64'(i0.in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; sb_en = 1'b0;
        for (int k = 0; k < 3; k++) n_out[k] = 0;
        ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        din0 = 18'd0; din1 = 11'd0; in_tag = 8'd0;

        //         a              b            i0 (29b)             i1           i2           i3           i4           ovf i4..i1
        vt[0] = '{18'(-131072), 11'd2047, 29'(-268304384), 16'(8192),  16'(8192),  16'(-32768), 16'(0),     4'b1111};
        vt[1] = '{18'(-25),     11'd3,    29'(-75),        16'(-5),    16'(-5),    16'(-75),    16'(-75),   4'b0000};
        vt[2] = '{18'(25),      11'd3,    29'(75),         16'(5),     16'(4),     16'(75),     16'(75),    4'b0000};
        vt[3] = '{18'(300),     11'd200,  29'(60000),      16'(3750),  16'(3750),  16'(32767),  16'(-5536), 4'b1100};
        vt[4] = '{18'(131071),  11'd2047, 29'(268302337),  16'(-8320), 16'(-8320), 16'(32767),  16'(-2047), 4'b1111};

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", 64'(i0.out_valid), 64'd0);
        chk("rst_dout", 64'(i0.dout), 64'd0);
        chk("rst_sticky", 64'(i0.ovf_sticky), 64'd0);
        ap_rst = 1'b0;
        chk("rst_in_ready", 64'(i0.in_ready), 64'd1);

        // Vector table: latency, products, rounding, saturation, wrap
        for (int i = 0; i < 5; i++) begin
            send_one(vt[i].a, vt[i].b, 8'(i + 1));
            @(negedge clk);
            chk("lat1_out_valid", 64'(i0.out_valid), 64'd0);
            chk("ns1_out_valid", 64'(i5.out_valid), 64'd1);
            chk("ns1_dout", 64'(i5.dout), 64'(vt[i].e0));
            @(negedge clk);
            chk("lat2_out_valid", 64'(i0.out_valid), 64'd0);
            @(negedge clk);
            chk("lat3_out_valid", 64'(i0.out_valid), 64'd1);
            chk("def_dout", 64'(i0.dout), 64'(vt[i].e0));
            chk("def_ovf", 64'(i0.ovf), 64'd0);
            chk("def_tag", 64'(i0.out_tag), 64'(i + 1));
            chk("rnd_dout", 64'(i1.dout), 64'(vt[i].e1));
            chk("rnd_ovf", 64'(i1.ovf), 64'(vt[i].ov[0]));
            chk("trunc_dout", 64'(i2.dout), 64'(vt[i].e2));
            chk("trunc_ovf", 64'(i2.ovf), 64'(vt[i].ov[1]));
            chk("sat_dout", 64'(i3.dout), 64'(vt[i].e3));
            chk("sat_ovf", 64'(i3.ovf), 64'(vt[i].ov[2]));
            chk("wrap_dout", 64'(i4.dout), 64'(vt[i].e4));
            chk("wrap_ovf", 64'(i4.ovf), 64'(vt[i].ov[3]));
        end

        // Sticky set, clear, and clear-over-set priority
        @(posedge clk); #1;
        chk("sticky_set", 64'(i3.ovf_sticky), 64'd1);
        chk("sticky_def", 64'(i0.ovf_sticky), 64'd0);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("sticky_clr", 64'(i3.ovf_sticky), 64'd0);
        clr_sticky = 1'b1;
        send_one(vt[3].a, vt[3].b, 8'd9);
        repeat (3) @(posedge clk); #1;
        chk("sticky_clr_prio", 64'(i3.ovf_sticky), 64'd0);
        clr_sticky = 1'b0;
        send_one(vt[3].a, vt[3].b, 8'd9);
        repeat (3) @(posedge clk); #1;
        chk("sticky_reset_again", 64'(i3.ovf_sticky), 64'd1);

        // Backpressure: 10 tags, out_ready low for 5 cycles mid-stream
        repeat (8) @(posedge clk); #1;
        sb_en = 1'b1;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 8 && c < 13);
            in_valid  = (sent < 10);
            din0      = 18'(sent * 1111 - 4000);
            din1      = 11'(sent * 150 + 7);
            in_tag    = 8'(sent + 1);
            @(negedge clk);
            if (c >= 8 && c < 13) begin
                chk("bp_in_ready", 64'(i0.in_ready), 64'd0);
                chk("bp_out_valid", 64'(i0.out_valid), 64'd1);
                if (c == 8) begin
                    hold_d = i0.dout;
                    hold_t = i0.out_tag;
                end else begin
                    chk("bp_hold_dout", 64'(i0.dout), 64'(hold_d));
                    chk("bp_hold_tag", 64'(i0.out_tag), 64'(hold_t));
                end
            end
            if (in_valid && i0.in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(n_out[0]), 64'd10);
        chk("bp_sb_empty", 64'(sbq[0].size()), 64'd0);

        // Random handshakes across stage counts 3, 1, 6
        tagc = 8'd100;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
            din0      = 18'($urandom);
            din1      = 11'($urandom);
            in_tag    = tagc;
            tagc      = tagc + 8'd1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk($sformatf("rand_sb%0d_empty", k), 64'(sbq[k].size()), 64'd0);

        // Asynchronous reset with three beats in flight
        send_one(vt[3].a, vt[3].b, 8'd40);
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_sticky", 64'(i3.ovf_sticky), 64'd1);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; din0 = vt[1].a; din1 = vt[1].b; in_tag = 8'(50 + j);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(i0.out_valid), 64'd1);
        #2 ap_rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(i0.out_valid), 64'd0);
        chk("arst_sticky", 64'(i3.ovf_sticky), 64'd0);
        chk("arst_dout", 64'(i0.dout), 64'd0);
        chk("arst_tag", 64'(i0.out_tag), 64'd0);
        chk("arst_ovf", 64'(i0.ovf), 64'd0);
        @(posedge clk); #1;
        ap_rst = 1'b0;
        chk("post_rst_in_ready", 64'(i0.in_ready), 64'd1);
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (i0.out_valid || i5.out_valid || i6.out_valid) stale = 1'b1;
        end
        chk("no_stale_beat", 64'(stale), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_mul_pipe.md
Name: tc_mul_pipe

Overview:
Parametrised, pipelined signed-by-unsigned multiplier for the TrackletCalculator datapath. It is the successor of the single-cycle 18s×11ns→29 DSP multiplier. It adds configurable operand and result widths, pipeline depth, a valid/ready handshake with backpressure, an optional rounding right-shift, saturation, and overflow reporting. A sideband tag travels with each product so callers can pair results with their stubs.

Parameters:
A_W, 18, width of signed operand din0
B_W, 11, width of unsigned operand din1 (zero-extended)
P_W, 29, width of signed result dout
SHIFT, 0, arithmetic right-shift applied to the full product before narrowing
ROUND, 0, 1 = round half-up before the shift (add 2^(SHIFT-1)); ignored when SHIFT=0
SAT, 0, 1 = saturate to P_W signed range; 0 = wrap (truncate to P_W LSBs)
NUM_STAGE, 3, pipeline depth in registers (legal range 1..6)
TAG_W, 8, sideband tag width

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
din0  in  A_W  signed multiplicand
din1  in  B_W  unsigned multiplier
in_tag  in  TAG_W  sideband tag, carried unmodified
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
dout  out  P_W  shifted, rounded, saturated/wrapped product
out_tag  out  TAG_W  tag of this result
ovf  out  1  this beat's value did not fit P_W (qualified by out_valid)
ovf_sticky  out  1  set by any accepted result with ovf=1
clr_sticky  in  1  synchronous clear of ovf_sticky

Behaviour:
- Full product: A_W+B_W bits, computed as signed(din0) × signed({1'b0,din1}); it never overflows internally.
- Round: when ROUND=1 and SHIFT>0, add 2^(SHIFT-1) to the full product. This addition is computed one bit wider so it cannot overflow. Then shift right arithmetically by SHIFT.
- Narrow: if the shifted value lies outside [-2^(P_W-1), 2^(P_W-1)-1], ovf=1. With SAT=1, dout clamps to the nearest bound. With SAT=0, dout is the low P_W bits.
- If P_W ≥ A_W+B_W-SHIFT (+1 when rounding), ovf is constant 0.
- Pipeline: NUM_STAGE valid-flagged register stages. Each stage holds data, tag and ovf.
- Global advance: adv = out_ready OR NOT out_valid. All stages shift when adv=1 and hold when adv=0.
- in_ready = adv. A beat is accepted when in_valid AND in_ready.
- Latency: an accepted beat appears on out_valid exactly NUM_STAGE cycles later if adv stays 1. Throughput is 1 beat/cycle.
- Stall: while out_valid=1 and out_ready=0, dout/out_tag/ovf stay stable and no beat is lost or duplicated.
- Bubbles propagate as valid=0; only valid flags need reset.
- ovf_sticky: set on an output handshake (out_valid AND out_ready AND ovf). On the same cycle, clr_sticky has priority over the set.
- Reset (asynchronous, at any time including mid-stream):
  - all valid flags clear, so out_valid=0;
  - ovf_sticky=0;
  - dout, out_tag and ovf reset to 0;
  - in_ready=1 from the first cycle after reset deasserts.
  - In-flight beats are discarded.
- NUM_STAGE=1: operands, multiply, round and narrow are combinational into a single output register.
- NUM_STAGE≥2: stage 1 registers operands and the last stage registers the narrowed result. Retiming is permitted, but the observable latency must stay NUM_STAGE.

Decomposition:
- Package tc_mul_pkg: function for the full-product width; function computing the saturation bounds for P_W; constants for the NUM_STAGE legal range; an elaboration check that NUM_STAGE is in 1..6 and SHIFT < A_W+B_W.
- One sub-module, tc_mul_narrow: purely combinational round, shift and saturate/wrap plus ovf. It is reused by other calculator blocks.

Test Plan:
1. Defaults, din0=-131072, din1=2047, always-ready -> dout=-268304384, ovf=0, out_valid exactly 3 cycles after acceptance.
2. SHIFT=4, ROUND=1, P_W=16, din0=-25, din1=3 -> dout=-5. Same with ROUND=0 -> dout=-5. With din0=25 -> ROUND=1 gives 5, ROUND=0 gives 4.
3. P_W=16, SHIFT=0, din0=300, din1=200 -> SAT=1: dout=32767, ovf=1, ovf_sticky=1. SAT=0: dout=-5536, ovf=1. Pulse clr_sticky -> ovf_sticky=0 next cycle.
4. Backpressure: stream tags 1..10 back-to-back, drop out_ready for 5 cycles mid-stream -> in_ready=0 during the stall, output held stable, all 10 tags emerge in order with correct products, none duplicated.
5. Random in_valid/out_ready (50%) across NUM_STAGE=1,3,6 against a reference model -> zero mismatches, in-order delivery.
6. Assert ap_rst asynchronously with 3 beats in flight -> out_valid=0 and ovf_sticky=0 immediately, no stale beat after release, in_ready=1 on the first cycle after release.
